// File: rtl/led_chaser_pkg.sv
// Shared types and helpers for the LED chaser pattern engine.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    ModeRotate = 2'b00,
    ModeBounce = 2'b01,
    ModeFill   = 2'b10,
    ModePause  = 2'b11
  } mode_e;

  // Width of the tick counter; holds up to the longest period minus one.
  localparam int unsigned CNT_W = 5;

  // Ticks per step: speed 0..3 maps to 32, 16, 8, 4.
  function automatic logic [CNT_W:0] period_of(input logic [1:0] speed);
    return (CNT_W + 1)'(32 >> speed);
  endfunction

endpackage

// File: rtl/led_chaser_if.sv
// Control and LED-drive bundle between the chaser and its surroundings.
interface led_chaser_if #(
  parameter int unsigned N_LEDS = 16
) ();
  localparam int unsigned W = $clog2(N_LEDS);

  logic              slw_clk;
  logic [1:0]        mode;
  logic [1:0]        speed;
  logic              dir;
  logic [N_LEDS-1:0] led;
  logic [W-1:0]      pos;
  logic              step;

  modport master (
    output slw_clk, mode, speed, dir,
    input  led, pos, step
  );

  modport slave (
    input  slw_clk, mode, speed, dir,
    output led, pos, step
  );
endinterface

// File: rtl/chase_step_timer.sv
// Turns rising edges of the slow square wave into step strobes every `period` ticks.
module chase_step_timer
  import led_chaser_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       slw_clk_i,
  input  logic [1:0] speed_i,
  input  logic       freeze_i,
  input  logic       clear_i,
  output logic       step_o
);

  logic             slw_q;
  logic             armed_q;
  logic             tick;
  logic             at_limit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   limit;

  // armed_q masks the first cycle after reset so a level that is already
  // high at release is not mistaken for a rising edge.
  assign tick     = slw_clk_i & ~slw_q & armed_q;
  assign limit    = period_of(speed_i) - {{CNT_W{1'b0}}, 1'b1};
  // >= so a mid-count speed increase fires on the next tick without overshoot.
  assign at_limit = {1'b0, cnt_q} >= limit;

  // Counter next state and step strobe; clear beats freeze beats tick.
  always_comb begin
    cnt_d  = cnt_q;
    step_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!freeze_i && tick) begin
      if (at_limit) begin
        cnt_d  = '0;
        step_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Edge-detect history and tick counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slw_q   <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      slw_q   <= slw_clk_i;
      armed_q <= 1'b1;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// LED pattern engine: rotate, bounce and fill patterns advanced by step strobes.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int unsigned N_LEDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  led_chaser_if.slave bus_io
);

  localparam int unsigned  W      = $clog2(N_LEDS);
  localparam logic [W-1:0] PosMax = W'(N_LEDS - 1);

  mode_e             mode_in;
  mode_e             mode_q, mode_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic [W-1:0]      pos_q, pos_d;
  logic              up_q, up_d;
  logic              step_q;
  logic              paused;
  logic              reload;
  logic              fire;

  // LED image for a given mode and position.
  function automatic logic [N_LEDS-1:0] pattern_of(input mode_e m, input logic [W-1:0] p,
                                                   input logic d);
    logic [N_LEDS-1:0] pat;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (m == ModeFill) begin
        pat[i] = d ? (i + 32'(p) >= N_LEDS - 1) : (i <= 32'(p));
      end else begin
        pat[i] = (i == 32'(p));
      end
    end
    return pat;
  endfunction

  assign mode_in = mode_e'(bus_io.mode);
  assign paused  = (mode_in == ModePause);
  // mode_q remembers the last non-pause mode, so pausing never forces a reload.
  assign reload  = !paused && (mode_in != mode_q);

  chase_step_timer u_timer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .slw_clk_i (bus_io.slw_clk),
    .speed_i   (bus_io.speed),
    .freeze_i  (paused),
    .clear_i   (reload),
    .step_o    (fire)
  );

  // Pattern next state: mode reload first, otherwise advance on a step.
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    led_d  = led_q;
    up_d   = up_q;
    if (reload) begin
      mode_d = mode_in;
      up_d   = 1'b1;
      pos_d  = (mode_in == ModeBounce || !bus_io.dir) ? '0 : PosMax;
      led_d  = pattern_of(mode_in, pos_d, bus_io.dir);
    end else if (fire) begin
      unique case (mode_q)
        ModeRotate: begin
          if (!bus_io.dir) pos_d = (pos_q == PosMax) ? '0 : pos_q + 1'b1;
          else             pos_d = (pos_q == '0) ? PosMax : pos_q - 1'b1;
        end
        ModeBounce: begin
          if (up_q) begin
            if (pos_q == PosMax) begin
              up_d  = 1'b0;
              pos_d = pos_q - 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              up_d  = 1'b1;
              pos_d = pos_q + 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        ModeFill: pos_d = (pos_q == PosMax) ? '0 : pos_q + 1'b1;
        default:  pos_d = pos_q;
      endcase
      led_d = pattern_of(mode_q, pos_d, bus_io.dir);
    end
  end

  // Pattern registers and the registered step pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= ModeRotate;
      pos_q  <= '0;
      led_q  <= {{(N_LEDS - 1){1'b0}}, 1'b1};
      up_q   <= 1'b1;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pos_q  <= pos_d;
      led_q  <= led_d;
      up_q   <= up_d;
      step_q <= fire;
    end
  end

  assign bus_io.led  = led_q;
  assign bus_io.pos  = pos_q;
  assign bus_io.step = step_q;

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser: directed table, corner sequences, random run.
module tb_led_chaser;

  localparam int N = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  led_chaser_if #(.N_LEDS(N)) bus ();

  led_chaser #(.N_LEDS(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int steps_seen;

  // Reference model state: rule-level view of the chaser.
  int m_led, m_pos, m_step, m_ticks, m_last, m_k, m_prev;

  typedef struct {
    int mode;
    int speed;
    int dir;
    int n_rises;
    int exp_led;
    int exp_pos;
    int exp_steps;
  } vec_t;

  vec_t vecs[9];

  function automatic int pattern(input int mode, input int pos, input int dir);
    if (mode == 2) begin
      if (dir != 0) return ((1 << N) - 1) & ~((1 << (N - 1 - pos)) - 1);
      return (1 << (pos + 1)) - 1;
    end
    return 1 << pos;
  endfunction

  task automatic check(input string name, input int got_led, input int got_pos,
                       input int got_step, input int exp_led, input int exp_pos,
                       input int exp_step);
    n_checks++;
    if (got_led == exp_led && got_pos == exp_pos && got_step == exp_step) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got led=%h pos=%0d step=%0d, want led=%h pos=%0d step=%0d",
               name, $time, got_led, got_pos, got_step, exp_led, exp_pos, exp_step);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, exp);
  endtask

  task automatic model_reset();
    m_led = 1; m_pos = 0; m_step = 0; m_ticks = 0; m_last = 0; m_k = 0;
    // Treat the wave as already high so a level present at release is no edge.
    m_prev = 1;
  endtask

  // One clock of the model using the inputs currently on the bus.
  task automatic model_cycle();
    int mode, speed, dir, slw, period;
    bit tick;
    mode   = int'(bus.mode);
    speed  = int'(bus.speed);
    dir    = int'(bus.dir);
    slw    = int'(bus.slw_clk);
    tick   = (slw == 1) && (m_prev == 0);
    m_prev = slw;
    period = 32 >> speed;
    m_step = 0;
    if (mode == 3) begin
      // frozen
    end else if (mode != m_last) begin
      m_last  = mode;
      m_ticks = 0;
      if (mode == 1) begin
        m_k   = 0;
        m_pos = 0;
      end else begin
        m_pos = (dir != 0) ? N - 1 : 0;
      end
      m_led = pattern(mode, m_pos, dir);
    end else if (tick) begin
      m_ticks++;
      if (m_ticks >= period) begin
        m_ticks = 0;
        m_step  = 1;
        case (mode)
          0: m_pos = (dir != 0) ? (m_pos + N - 1) % N : (m_pos + 1) % N;
          1: begin
            m_k   = (m_k + 1) % (2 * N - 2);
            m_pos = (m_k < N) ? m_k : 2 * N - 2 - m_k;
          end
          default: m_pos = (m_pos + 1) % N;
        endcase
        m_led = pattern(mode, m_pos, dir);
      end
    end
  endtask

  task automatic cyc(input string name);
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    if (bus.step) steps_seen++;
    check(name, int'(bus.led), int'(bus.pos), int'(bus.step), m_led, m_pos, m_step);
  endtask

  task automatic rises(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      bus.slw_clk = 1'b1;
      cyc(name);
      bus.slw_clk = 1'b0;
      cyc(name);
    end
  endtask

  // Assert reset between edges, hold it with busy inputs, then release.
  task automatic do_reset(input logic slw_rel, input logic [1:0] mode_rel);
    #2 reset = 1'b0;
    #1 check("reset_async", int'(bus.led), int'(bus.pos), int'(bus.step), 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.slw_clk = 1'($urandom_range(0, 1));
      bus.mode    = 2'($urandom_range(0, 3));
      bus.speed   = 2'($urandom_range(0, 3));
      bus.dir     = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check("reset_hold", int'(bus.led), int'(bus.pos), int'(bus.step), 1, 0, 0);
    end
    bus.slw_clk = slw_rel;
    bus.mode    = mode_rel;
    bus.speed   = 2'd3;
    bus.dir     = 1'b0;
    reset       = 1'b1;
    model_reset();
  endtask

  initial begin
    int half;
    vecs[0] = '{0, 3, 0,   4, 'h0002,  1,  1};
    vecs[1] = '{0, 3, 0,  60, 'h0001,  0, 15};
    vecs[2] = '{1, 2, 0, 120, 'h8000, 15, 15};
    vecs[3] = '{1, 2, 0,   8, 'h4000, 14,  1};
    vecs[4] = '{2, 2, 0, 120, 'hFFFF, 15, 15};
    vecs[5] = '{2, 2, 0,   8, 'h0001,  0,  1};
    vecs[6] = '{3, 2, 0,  20, 'h0001,  0,  0};
    vecs[7] = '{0, 3, 1,   0, 'h8000, 15,  0};
    vecs[8] = '{0, 3, 1,   4, 'h4000, 14,  1};

    bus.slw_clk = 1'b0;
    bus.mode    = 2'd0;
    bus.speed   = 2'd3;
    bus.dir     = 1'b0;
    @(negedge clk);
    do_reset(1'b0, 2'd0);

    // Directed table; each entry starts with one settle cycle for mode reloads.
    for (int i = 0; i < 9; i++) begin
      bus.mode   = 2'(vecs[i].mode);
      bus.speed  = 2'(vecs[i].speed);
      bus.dir    = 1'(vecs[i].dir);
      steps_seen = 0;
      cyc("vec_settle");
      rises(vecs[i].n_rises, "vec_run");
      check($sformatf("vec%0d_end", i), int'(bus.led), int'(bus.pos), int'(bus.step),
            vecs[i].exp_led, vecs[i].exp_pos, 0);
      check_int($sformatf("vec%0d_steps", i), steps_seen, vecs[i].exp_steps);
    end

    // Pause at pos 5 mid-period, then resume.
    bus.mode  = 2'd1;
    bus.speed = 2'd3;
    cyc("bounce_settle");
    rises(20, "bounce_to5");
    check("bounce_pos5", int'(bus.led), int'(bus.pos), int'(bus.step), 'h0020, 5, 0);
    rises(2, "pre_pause");
    bus.mode   = 2'd3;
    steps_seen = 0;
    rises(100, "paused");
    check("pause_hold", int'(bus.led), int'(bus.pos), int'(bus.step), 'h0020, 5, 0);
    check_int("pause_steps", steps_seen, 0);
    bus.mode = 2'd1;
    cyc("resume");
    rises(1, "resume_r1");
    check("resume_partial", int'(bus.led), int'(bus.pos), int'(bus.step), 'h0020, 5, 0);
    steps_seen = 0;
    rises(1, "resume_r2");
    check("resume_step", int'(bus.led), int'(bus.pos), int'(bus.step), 'h0040, 6, 0);
    check_int("resume_steps", steps_seen, 1);

    // Reset mid-period, released with the slow wave already high.
    rises(2, "pre_reset");
    do_reset(1'b1, 2'd0);
    cyc("rel_high0");
    cyc("rel_high1");
    bus.slw_clk = 1'b0;
    cyc("rel_low");
    steps_seen = 0;
    rises(3, "post_reset3");
    check("post_reset_no_step", int'(bus.led), int'(bus.pos), int'(bus.step), 'h0001, 0, 0);
    rises(1, "post_reset4");
    check("post_reset_step", int'(bus.led), int'(bus.pos), int'(bus.step), 'h0002, 1, 0);
    check_int("post_reset_steps", steps_seen, 1);

    // Tick arriving with a mode change is dropped in favour of the reload.
    rises(3, "pre_collide");
    bus.slw_clk = 1'b1;
    bus.mode    = 2'd2;
    cyc("collide");
    check("collide_reload", int'(bus.led), int'(bus.pos), int'(bus.step), 'h0001, 0, 0);
    bus.slw_clk = 1'b0;
    cyc("collide_low");
    steps_seen = 0;
    rises(3, "collide_r3");
    check_int("collide_no_step", steps_seen, 0);
    rises(1, "collide_r4");
    check("collide_step", int'(bus.led), int'(bus.pos), int'(bus.step), 'h0003, 1, 0);

    // Random run against the model.
    half = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bus.speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) bus.dir = 1'($urandom_range(0, 1));
      half--;
      if (half == 0) begin
        bus.slw_clk = ~bus.slw_clk;
        half = $urandom_range(1, 3);
      end
      cyc("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
